// File: rtl/fc_mac_array.sv
// Fully-connected MAC array: NUM_PE signed lanes share a broadcast activation per beat.
// Optional macro FC_RELU_EN clamps negative lane totals to zero when results are loaded.
module fc_mac_array #(
    parameter int NUM_PE   = 100,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int MAX_LEN  = 1024,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_last_i,
    input  logic signed [DATA_W-1:0]   pixel_i,
    input  logic signed [WEIGHT_W-1:0] weights_i [NUM_PE],
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [ACC_W-1:0]    results_o [NUM_PE],
    output logic [CNT_W-1:0]           beat_count_o,
    output logic                       overflow_o
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    typedef enum logic {S_ACC, S_OUT} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_PE];
    logic signed [ACC_W-1:0]  acc_d [NUM_PE];
    logic signed [ACC_W-1:0]  res_q [NUM_PE];
    logic signed [ACC_W-1:0]  res_d [NUM_PE];
    logic signed [PROD_W-1:0] prod  [NUM_PE];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         bcnt_q, bcnt_d;
    logic                     first_q, first_d;
    logic                     ovf_q, ovf_d;
    logic                     accept;

    always_comb begin
        accept  = in_valid_i && (state_q == S_ACC);
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        first_d = first_q;
        ovf_d   = ovf_q;

        for (int unsigned i = 0; i < NUM_PE; i++) begin
            prod[i]  = PROD_W'(pixel_i) * PROD_W'(weights_i[i]);
            acc_d[i] = acc_q[i];
            res_d[i] = res_q[i];
        end

        if (accept) begin
            // First beat overwrites the lane, so no explicit clear is needed between vectors.
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                acc_d[i] = first_q ? ACC_W'(prod[i]) : acc_q[i] + ACC_W'(prod[i]);
            end
            if (first_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_W'(MAX_LEN)) begin
                cnt_d = cnt_q;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            first_d = in_last_i;
            if (in_last_i) begin
                state_d = S_OUT;
                bcnt_d  = cnt_d;
                for (int unsigned i = 0; i < NUM_PE; i++) begin
`ifdef FC_RELU_EN
                    res_d[i] = acc_d[i][ACC_W-1] ? '0 : acc_d[i];
`else
                    res_d[i] = acc_d[i];
`endif
                end
            end
        end

        if (state_q == S_OUT && out_ready_i) begin
            state_d = S_ACC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign in_ready_o   = (state_q == S_ACC);
    assign out_valid_o  = (state_q == S_OUT);
    assign results_o    = res_q;
    assign beat_count_o = bcnt_q;
    assign overflow_o   = ovf_q;

endmodule
